// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            requesters, with overflow retry and wr_ack/overflow checking.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          busy,
    output logic [7:0]                    retry_cnt,
    output logic                          proto_err
);

    localparam int               c_idx_w     = $clog2(NUM_REQ);
    localparam logic [1:0]       c_idle      = 2'd0;
    localparam logic [1:0]       c_write     = 2'd1;
    localparam logic [1:0]       c_check     = 2'd2;
    localparam logic [c_idx_w-1:0] c_last_init = c_idx_w'(NUM_REQ - 1);

    logic [1:0]            r_state;
    logic [c_idx_w-1:0]    r_winner;
    logic [c_idx_w-1:0]    r_last_gnt;
    logic                  r_retry_pend;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_wr_en;
    logic [7:0]            r_retry_cnt;
    logic                  r_proto_err;

    logic [c_idx_w:0]      w_idle_pick;
    logic [c_idx_w:0]      w_next_pick;
    logic [DATA_WIDTH-1:0] w_idle_data;
    logic [DATA_WIDTH-1:0] w_next_data;
    logic [NUM_REQ-1:0]    w_winner_oh;
    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_held_valid;
    logic                  w_ack_ok;

    // Returns {found, index} of the first set bit of mask after base, with wrap.
    function automatic logic [c_idx_w:0] rr_pick(
        input logic [NUM_REQ-1:0] mask,
        input logic [c_idx_w-1:0] base
    );
        logic [c_idx_w:0]   res;
        logic [c_idx_w-1:0] pidx;
        int                 pos;
        res = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos  = (int'(base) + k) % NUM_REQ;
            pidx = pos[c_idx_w-1:0];
            if (!res[c_idx_w] && mask[pidx]) begin
                res = {1'b1, pidx};
            end
        end
        return res;
    endfunction

    assign w_winner_oh  = NUM_REQ'(1) << r_winner;
    assign w_held_valid = r_retry_pend && req[r_winner];
    assign w_ack_ok     = fifo_wr_ack && !fifo_overflow;
    assign w_gnt        = (r_state == c_check && w_ack_ok) ? w_winner_oh : '0;

    // A pending retry keeps its slot as long as the requester still holds req.
    always_comb begin
        w_idle_pick = rr_pick(req, r_last_gnt);
        if (w_held_valid) begin
            w_idle_pick = {1'b1, r_winner};
        end
    end

    assign w_next_pick = rr_pick(req & ~w_gnt, r_winner);
    assign w_idle_data = req_data[w_idle_pick[c_idx_w-1:0]*DATA_WIDTH +: DATA_WIDTH];
    assign w_next_data = req_data[w_next_pick[c_idx_w-1:0]*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_idle;
            r_winner     <= '0;
            r_last_gnt   <= c_last_init;
            r_retry_pend <= 1'b0;
            r_data       <= '0;
            r_wr_en      <= 1'b0;
            r_retry_cnt  <= 8'd0;
            r_proto_err  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (r_retry_pend && !req[r_winner]) begin
                        r_retry_pend <= 1'b0;
                    end
                    if (w_idle_pick[c_idx_w] && !fifo_full) begin
                        r_winner <= w_idle_pick[c_idx_w-1:0];
                        r_data   <= w_idle_data;
                        r_wr_en  <= 1'b1;
                        r_state  <= c_write;
                    end else begin
                        r_wr_en  <= 1'b0;
                    end
                end
                c_write: begin
                    r_wr_en <= 1'b0;
                    r_state <= c_check;
                end
                c_check: begin
                    if (w_ack_ok) begin
                        r_last_gnt   <= r_winner;
                        r_retry_pend <= 1'b0;
                        if (w_next_pick[c_idx_w] && !fifo_full) begin
                            r_winner <= w_next_pick[c_idx_w-1:0];
                            r_data   <= w_next_data;
                            r_wr_en  <= 1'b1;
                            r_state  <= c_write;
                        end else begin
                            r_state  <= c_idle;
                        end
                    end else begin
                        // Missing or contradictory response is retried like an overflow.
                        if (fifo_wr_ack == fifo_overflow) begin
                            r_proto_err <= 1'b1;
                        end
                        r_retry_pend <= 1'b1;
                        if (r_retry_cnt != 8'hFF) begin
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                        end
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_wr_en <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign gnt          = w_gnt;
    assign fifo_data_in = r_data;
    assign fifo_wr_en   = r_wr_en;
    assign busy         = (r_state != c_idle);
    assign retry_cnt    = r_retry_cnt;
    assign proto_err    = r_proto_err;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the FIFO between NUM_REQ requesters. It sits between the requester-side logic and the FIFO write interface. It issues one write at a time, checks the FIFO's wr_ack/overflow response, and re-issues the same word after an overflow. It returns a one-cycle grant to the requester whose word was accepted.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 16: FIFO word width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; held high with data stable until that requester's gnt.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: requester's word accepted by FIFO.
- fifo_data_in  out  DATA_WIDTH  registered; to FIFO data_in.
- fifo_wr_en  out  1  registered; to FIFO wr_en.
- fifo_full  in  1  FIFO full.
- fifo_wr_ack  in  1  FIFO wr_ack; registered in FIFO, one cycle after wr_en.
- fifo_overflow  in  1  FIFO overflow; registered in FIFO, one cycle after wr_en.
- busy  out  1  state != IDLE.
- retry_cnt  out  8  overflow-retry count, saturates at 255.
- proto_err  out  1  sticky: CHECK cycle saw neither wr_ack nor overflow, or saw both.

## Operation
- States: IDLE, WRITE, CHECK.
- Registers: winner (index), last_gnt (index), retry_pend (1 bit), plus the outputs.
- Selection: the winner is the first requester with req=1, searching from (last_gnt+1) mod NUM_REQ upward with wrap.
  - If retry_pend=1, the held winner is reused and no new search is made.
  - If the held winner has dropped req, retry_pend clears and a new search is made.
- IDLE: if a candidate exists and fifo_full=0:
  - load fifo_data_in from the winner's slice, set fifo_wr_en=1, go to WRITE.
  - Otherwise stay in IDLE with fifo_wr_en=0.
- WRITE: the FIFO samples wr_en/data at the closing edge. Set fifo_wr_en=0, go to CHECK.
- CHECK, wr_ack=1: gnt[winner]=1 (combinational, this cycle only), last_gnt<=winner, retry_pend<=0.
  - If another candidate exists (req masked by the current gnt) and fifo_full=0: launch the next write directly and go to WRITE.
  - Otherwise go to IDLE.
- CHECK, overflow=1: no gnt, retry_pend<=1, retry_cnt++ (saturating), go to IDLE; last_gnt is unchanged.
- CHECK, neither or both asserted: proto_err<=1, treated as overflow (retry).
- gnt is never asserted outside CHECK. At most one bit is high.
- Fairness: last_gnt advances only on an acknowledged write, so a retried requester keeps its slot.

## Timing
- Reset values: state=IDLE, fifo_wr_en=0, fifo_data_in=0, gnt=0, busy=0, retry_cnt=0, proto_err=0, retry_pend=0, winner=0, last_gnt=NUM_REQ-1 (requester 0 wins first).
- Reset mid-operation clears all state immediately. An in-flight write is abandoned; no gnt is issued for it.
- Latency: req rising in cycle N (IDLE, not full):
  - fifo_wr_en high in cycle N+1;
  - gnt in cycle N+2 (same cycle as wr_ack).
- Throughput: one write per 2 cycles with continuous requests.
- fifo_full is sampled only in IDLE and CHECK. It is the post-write value, so no write is issued while the FIFO is full.
- A requester deasserting req before gnt is a requester error. The arbiter drops it at the next selection point.

## Test plan
- Single requester: reset, req[0]=1 with data 0x00A5 while the FIFO has space.
  - Required: fifo_wr_en high the next cycle with fifo_data_in=0x00A5, gnt=4'b0001 one cycle later, busy low afterward.
- All four requesting continuously, FIFO never full.
  - Required: gnt order 0,1,2,3,0,1... and one gnt every 2 cycles.
- FIFO full at request time.
  - Required: no fifo_wr_en while fifo_full=1. The write issues on the first IDLE cycle after full drops.
- Forced overflow response in CHECK for requester 2.
  - Required: no gnt, retry_cnt=1, the same word re-issued to requester 2 before any other requester, then gnt=4'b0100.
- Responder returns neither wr_ack nor overflow.
  - Required: proto_err=1 and stays high; the word is re-issued.
- rst pulsed while in WRITE.
  - Required: all outputs return to reset values immediately; requester 0 wins the next arbitration.
